// File: rtl/cga_serializer.sv
// -----------------------------------------------------------------------------
// cga_serializer
//
// Text-mode pixel serializer feeding the CGA colour-line decoder. One character
// cell row (glyph bitmap + IRGB attribute) is accepted per handshake. The glyph
// is then shifted out one pixel per clock, MSB first. Attribute blink and the
// cursor overlay are applied when the cell is loaded.
//
// color_o leads on_o by one clock. The decoder registers the attribute but uses
// pixel-on directly, so the two line up at the decoder output.
//
// Handshake: a cell is accepted on a rising edge where load_i & ready_o.
// ready_o is combinational from the remaining-pixel count and is high while at
// most one pixel is still pending. A load_i without ready_o is dropped, and
// nothing of it is remembered. The pending pixel count reaches zero exactly
// when the next cell is accepted, so a producer that loads whenever ready_o is
// high streams with no gap.
//
// Ports:
//   clk_i     pixel clock
//   rst_ni    asynchronous active-low reset
//   glyph_i   glyph row bitmap, MSB = leftmost pixel
//   attr_i    attribute byte, background [7:4], foreground [3:0]
//   cursor_i  cell is under the cursor (sampled with the load)
//   load_i    glyph/attr valid
//   ready_o   serializer accepts a load this cycle
//   frame_i   one-cycle pulse per frame, drives the blink timer
//   color_o   registered attribute to the decoder
//   on_o      registered pixel-on to the decoder
// -----------------------------------------------------------------------------
module cga_serializer #(
  parameter int GLYPH_W      = 8,
  parameter int BLINK_EN     = 1,
  parameter int BLINK_FRAMES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [GLYPH_W-1:0] glyph_i,
  input  logic [7:0]         attr_i,
  input  logic               cursor_i,
  input  logic               load_i,
  output logic               ready_o,
  input  logic               frame_i,
  output logic [7:0]         color_o,
  output logic               on_o
);

  localparam int RW = $clog2(GLYPH_W + 1);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [RW-1:0] REM_FULL  = RW'(GLYPH_W);
  localparam logic [RW-1:0] REM_ONE   = RW'(1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [GLYPH_W-1:0] sreg_q, sreg_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [7:0]         color_q, color_d;
  logic               on_q, on_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic               phase_q, phase_d;

  logic               accept;
  logic [GLYPH_W-1:0] eff_glyph;
  logic [7:0]         eff_attr;

  assign ready_o = (rem_q <= REM_ONE);
  assign accept  = load_i & ready_o;
  assign color_o = color_q;
  assign on_o    = on_q;

  // Blink timer: phase 0 is the visible half of the blink cycle.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_i) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Cell effects use the phase before any toggle in this same cycle. The
  // cursor overrides the blink mask while visible. In the hidden phase it
  // falls back to the (possibly masked) glyph.
  always_comb begin
    if (cursor_i && !phase_q) begin
      eff_glyph = '1;
    end else if ((BLINK_EN != 0) && attr_i[7] && phase_q) begin
      eff_glyph = '0;
    end else begin
      eff_glyph = glyph_i;
    end
    eff_attr = (BLINK_EN != 0) ? {1'b0, attr_i[6:0]} : attr_i;
  end

  // Pixel pipeline. On the accepting edge the last pixel of the previous cell
  // is still driven from sreg_q while sreg_q is reloaded. That overlap is what
  // makes back-to-back cells gapless.
  always_comb begin
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    color_d = color_q;
    on_d    = 1'b0;
    if (rem_q != '0) begin
      on_d   = sreg_q[GLYPH_W-1];
      sreg_d = {sreg_q[GLYPH_W-2:0], 1'b0};
      rem_d  = rem_q - REM_ONE;
    end
    if (accept) begin
      sreg_d  = eff_glyph;
      color_d = eff_attr;
      rem_d   = REM_FULL;
    end else if (rem_q == REM_ONE) begin
      // Underrun: drop the attribute one clock ahead of the final pixel so
      // that the decoder sees black once the cell ends.
      color_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q  <= '0;
      rem_q   <= '0;
      color_q <= '0;
      on_q    <= 1'b0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      color_q <= color_d;
      on_q    <= on_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: tb/tb_cga_serializer.sv
// -----------------------------------------------------------------------------
// tb_cga_serializer
//
// Two serializers share the same stimulus: one with blink enabled and
// BLINK_FRAMES = 2, and one with blink disabled and BLINK_FRAMES = 3.
//
// The reference model records, for each accepted cell, what every output
// should show after each clock edge. It keeps a timeline indexed by edge
// number:
//   - the attribute on color_o from the accept edge for GLYPH_W clocks,
//   - pixel k on on_o after edge accept+1+k,
//   - a busy mark on every pixel edge.
// ready_o after edge t is high when no pixel is still scheduled at edge t+2 or
// later. The blink phase is derived from the number of frame pulses.
// -----------------------------------------------------------------------------
module tb_cga_serializer;

  localparam int W    = 8;
  localparam int MAXC = 4096;

  logic         clk;
  logic         rst_ni;
  logic [W-1:0] glyph_i;
  logic [7:0]   attr_i;
  logic         cursor_i;
  logic         load_i;
  logic         frame_i;
  logic         ready_b, on_b, ready_n, on_n;
  logic [7:0]   color_b, color_n;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model timeline, [0] = blink DUT, [1] = no-blink DUT.
  bit         on_at    [2][MAXC];
  bit         busy_at  [2][MAXC];
  logic [7:0] color_at [2][MAXC];
  int         fcount   [2];
  int         bf       [2];
  int         ben      [2];

  cga_serializer #(.GLYPH_W(W), .BLINK_EN(1), .BLINK_FRAMES(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .glyph_i(glyph_i), .attr_i(attr_i),
    .cursor_i(cursor_i), .load_i(load_i), .ready_o(ready_b),
    .frame_i(frame_i), .color_o(color_b), .on_o(on_b)
  );

  cga_serializer #(.GLYPH_W(W), .BLINK_EN(0), .BLINK_FRAMES(3)) dut_n (
    .clk_i(clk), .rst_ni(rst_ni), .glyph_i(glyph_i), .attr_i(attr_i),
    .cursor_i(cursor_i), .load_i(load_i), .ready_o(ready_n),
    .frame_i(frame_i), .color_o(color_n), .on_o(on_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_ready(input int m);
    return !busy_at[m][cyc+2];
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      fcount[m] = 0;
      for (int i = 0; i < MAXC; i++) begin
        on_at[m][i]    = 1'b0;
        busy_at[m][i]  = 1'b0;
        color_at[m][i] = 8'h00;
      end
    end
  endfunction

  function automatic void model_accept(input int m, input int e, input logic [W-1:0] g,
                                       input logic [7:0] a, input bit cur);
    int           ph;
    logic [W-1:0] eg;
    logic [7:0]   ea;
    ph = (fcount[m] / bf[m]) % 2;
    if (cur && ph == 0)                    eg = '1;
    else if (ben[m] != 0 && a[7] && ph == 1) eg = '0;
    else                                   eg = g;
    ea = (ben[m] != 0) ? {1'b0, a[6:0]} : a;
    for (int k = 0; k < W; k++) begin
      color_at[m][e+k]   = ea;
      on_at[m][e+1+k]    = eg[W-1-k];
      busy_at[m][e+1+k]  = 1'b1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_outs();
    chk("on_b",    {31'd0, on_b},    {31'd0, on_at[0][cyc]});
    chk("color_b", {24'd0, color_b}, {24'd0, color_at[0][cyc]});
    chk("ready_b", {31'd0, ready_b}, {31'd0, model_ready(0)});
    chk("on_n",    {31'd0, on_n},    {31'd0, on_at[1][cyc]});
    chk("color_n", {24'd0, color_n}, {24'd0, color_at[1][cyc]});
    chk("ready_n", {31'd0, ready_n}, {31'd0, model_ready(1)});
  endtask

  // Called just after a falling edge. It checks the state left by edge cyc,
  // then drives the inputs for edge cyc+1.
  task automatic step(input bit ld, input logic [W-1:0] g, input logic [7:0] a,
                      input bit cur, input bit fr);
    check_outs();
    load_i   = ld;
    glyph_i  = g;
    attr_i   = a;
    cursor_i = cur;
    frame_i  = fr;
    for (int m = 0; m < 2; m++) begin
      if (ld && model_ready(m)) model_accept(m, cyc + 1, g, a, cur);
      if (fr) fcount[m]++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    load_i  = 1'b0;
    frame_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    load_i  = 1'b0;
    frame_i = 1'b0;
    #1;
    chk("rst_on_b",    {31'd0, on_b},    32'd0);
    chk("rst_color_b", {24'd0, color_b}, 32'd0);
    chk("rst_ready_b", {31'd0, ready_b}, 32'd1);
    chk("rst_on_n",    {31'd0, on_n},    32'd0);
    chk("rst_color_n", {24'd0, color_n}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_clear();
    cyc = 0;
  endtask

  // Load one cell when the serializer is free, then gather its eight pixels.
  task automatic run_cell(input logic [W-1:0] g, input logic [7:0] a, input bit cur,
                          output logic [W-1:0] pix_b, output logic [W-1:0] pix_n,
                          output logic [7:0] col_b, output logic [7:0] col_n);
    int guard;
    guard = 0;
    while (!model_ready(0) && guard < 40) begin
      step(1'b0, '0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    step(1'b1, g, a, cur, 1'b0);
    col_b = color_b;
    col_n = color_n;
    for (int k = 0; k < W; k++) begin
      step(1'b0, '0, 8'h00, 1'b0, 1'b0);
      pix_b[W-1-k] = on_b;
      pix_n[W-1-k] = on_n;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] pb, pn;
  logic [7:0]   cb, cn;
  logic [W-1:0] sg [4];
  logic [7:0]   sa [4];

  initial begin
    bf[0] = 2; bf[1] = 3;
    ben[0] = 1; ben[1] = 0;
    rst_ni = 1'b0; load_i = 1'b0; frame_i = 1'b0;
    glyph_i = '0; attr_i = 8'h00; cursor_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Single cell.
    run_cell(8'hA5, 8'h1E, 1'b0, pb, pn, cb, cn);
    chk("single_pix", {24'd0, pb}, 32'h A5);
    chk("single_col", {24'd0, cb}, 32'h 1E);
    repeat (3) step(1'b0, '0, 8'h00, 1'b0, 1'b0);

    // Streaming: load held high, four cells back to back.
    do_reset();
    sg[0] = 8'hFF; sg[1] = 8'h00; sg[2] = 8'h81; sg[3] = 8'h3C;
    sa[0] = 8'h07; sa[1] = 8'h70; sa[2] = 8'h4F; sa[3] = 8'h1A;
    for (int idx = 0; idx < 4; ) begin
      if (model_ready(0)) begin
        step(1'b1, sg[idx], sa[idx], 1'b0, 1'b0);
        idx++;
      end else begin
        step(1'b1, 8'h55, 8'h33, 1'b0, 1'b0);
      end
    end
    repeat (12) step(1'b0, '0, 8'h00, 1'b0, 1'b0);

    // Blink: cells between frame pulses; frames 2-3 are the hidden phase.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      run_cell(8'hFF, 8'h8F, 1'b0, pb, pn, cb, cn);
      chk("blink_pix",  {24'd0, pb}, (j == 2 || j == 3) ? 32'h00 : 32'hFF);
      chk("blink_col",  {24'd0, cb}, 32'h0F);
      chk("noblink_pix", {24'd0, pn}, 32'hFF);
      chk("noblink_col", {24'd0, cn}, 32'h8F);
      if (j == 2) begin
        run_cell(8'hFF, 8'h0F, 1'b0, pb, pn, cb, cn);
        chk("plain_attr_pix", {24'd0, pb}, 32'hFF);
      end
      step(1'b0, '0, 8'h00, 1'b0, 1'b1);
    end

    // Cursor: visible phase forces all-on, hidden phase shows the glyph.
    do_reset();
    run_cell(8'h00, 8'h07, 1'b1, pb, pn, cb, cn);
    chk("cursor_ph0", {24'd0, pb}, 32'hFF);
    step(1'b0, '0, 8'h00, 1'b0, 1'b1);
    step(1'b0, '0, 8'h00, 1'b0, 1'b1);
    run_cell(8'h00, 8'h07, 1'b1, pb, pn, cb, cn);
    chk("cursor_ph1", {24'd0, pb}, 32'h00);
    chk("cursor_nb",  {24'd0, pn}, 32'hFF);

    // Ignored loads while busy, then reset at pixel 3.
    do_reset();
    step(1'b1, 8'hC3, 8'h2A, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 8'h0F, 8'h55, 1'b1, 1'b0);
    do_reset();
    repeat (12) step(1'b0, '0, 8'h00, 1'b0, 1'b0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0 || cyc > 3000) begin
        do_reset();
      end else begin
        step($urandom_range(0, 1) == 1, W'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
    end
    check_outs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
